wave_gen: RTL and testbench
===========================

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have: n_rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have: en  input  1  generator enable; low = hold.
REQ-004 SHALL have: mode  input  2  wave select (0 square, 1 sawtooth, 2 triangle, 3 noise), driven by the wave-type selector.
REQ-005 SHALL have: freq_div  input  16  clock cycles per phase step minus one.
REQ-006 SHALL have: sample  output  8  unsigned wave sample, registered.
REQ-007 SHALL have: sample_valid  output  1  one-cycle pulse per new sample, registered.
REQ-008 Clocking/reset fixed: single clock clk; reset n_rst asynchronous, active-low.

Function
REQ-009 SHALL hold internal state: div_cnt (16 b), phase (8 b), active_mode (2 b), lfsr (8 b, noise build only).
REQ-010 Step condition: en=1 and div_cnt >= freq_div (live value); freq_div=0 steps every cycle.
REQ-011 On step edge: div_cnt<=0, phase<=phase+1 (255 wraps to 0), sample<=f(new phase, mode in effect), sample_valid<=1.
REQ-012 Non-step cycle with en=1: div_cnt<=div_cnt+1, sample holds, sample_valid<=0.
REQ-013 en=0: div_cnt, phase, lfsr, sample hold; sample_valid<=0; active_mode<=mode every cycle.
REQ-014 Mode change while en=1 SHALL apply only on the step whose new phase is 0: active_mode<=mode, and that step's sample uses the new mode (glitch-free switch at wave boundary).
REQ-015 freq_div lowered below current div_cnt: step on next cycle (>= compare), no 65536-cycle stall.
REQ-016 Square: sample = 0xFF if phase<128, else 0x00.
REQ-017 Sawtooth: sample = phase.
REQ-018 Triangle: sample = {phase[6:0],0} if phase<128, else {~phase[6:0],0} (8-bit, no saturation).
REQ-019 Noise (mode 3, macro defined): lfsr shifts left each step, new bit0 = b7^b5^b4^b3; sample = new lfsr value.
REQ-020 sample SHALL change only on step edges or reset.

Reset
REQ-021 n_rst low SHALL immediately force sample=0x00, sample_valid=0, div_cnt=0, phase=0, active_mode=0, lfsr=0x01.
REQ-022 Reset mid-operation SHALL abandon the current period; first step after release yields phase 1.
REQ-023 No output SHALL be X after reset for any input values.

Configuration
REQ-024 Macro WAVE_GEN_NOISE_EN: defined -> lfsr present, mode 3 per REQ-019.
REQ-025 Undefined -> no lfsr flops; mode 3 SHALL produce constant sample 0x80 on each step, sample_valid still pulses.

Verification
REQ-026 Reset, mode=1, freq_div=0, en 0->1: sample 0x01,0x02,0x03... every cycle, sample_valid constant 1; after 0xFF next sample 0x00.
REQ-027 mode=0, freq_div=3: sample_valid every 4th cycle; phases 1..127 give 0xFF, phase 128 gives 0x00.
REQ-028 mode=2, freq_div=0: phase 64 -> 0x80, phase 127 -> 0xFE, phase 128 -> 0xFE, phase 255 -> 0x00.
REQ-029 mode=1 running, mode changed to 0 at phase 100: sawtooth continues 101..255, step to phase 0 outputs 0xFF (square), then square.
REQ-030 freq_div=9, en dropped at div_cnt=5 for 20 cycles: no sample_valid, outputs hold; resume steps after 4 more en cycles; n_rst pulse mid-count -> sample 0x00, valid 0, next step phase 1.
REQ-031 WAVE_GEN_NOISE_EN defined, mode=3, freq_div=0 from reset: samples 0x02,0x04,0x08,0x11,0x23; undefined: all samples 0x80.

Source files
------------

// File: rtl/wave_gen.sv
// -----------------------------------------------------------------------------
// wave_gen -- programmable-rate 8-bit waveform generator
//
// A 16-bit divider advances an 8-bit phase accumulator once every
// (freq_div + 1) enabled cycles. Each phase step produces a new registered
// sample and a one-cycle sample_valid pulse. The sample is a function of the
// new phase and the wave mode in effect.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   n_rst         in   1   asynchronous active-low reset
//   en            in   1   generator enable (low = hold everything)
//   mode          in   2   0 square, 1 sawtooth, 2 triangle, 3 noise
//   freq_div      in  16   clock cycles per phase step minus one
//   sample        out  8   unsigned wave sample (registered)
//   sample_valid  out  1   one-cycle pulse per new sample (registered)
//
// Build option:
//   WAVE_GEN_NOISE_EN  defined   -> 8-bit LFSR present, mode 3 outputs noise
//                      undefined -> no LFSR, mode 3 outputs constant 0x80
// -----------------------------------------------------------------------------
module wave_gen (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] freq_div,
    output logic [7:0]  sample,
    output logic        sample_valid
);

    logic [15:0] r_div_cnt;
    logic [7:0]  r_phase;
    logic [1:0]  r_active_mode;
    logic [7:0]  r_sample;
    logic        r_sample_valid;

    logic        w_step;
    logic [7:0]  w_phase_next;
    logic [1:0]  w_mode_eff;
    logic [7:0]  w_square;
    logic [7:0]  w_triangle;
    logic [7:0]  w_noise;
    logic [7:0]  w_wave;

    // ">=" rather than "==" so that lowering freq_div below the running count
    // steps on the next cycle instead of waiting for the counter to wrap.
    assign w_step       = en && (r_div_cnt >= freq_div);
    assign w_phase_next = r_phase + 8'd1;

    // A pending mode change only takes effect on the step that lands on
    // phase 0, so a waveform is never switched part-way through its period.
    assign w_mode_eff   = (w_phase_next == 8'd0) ? mode : r_active_mode;

    assign w_square     = w_phase_next[7] ? 8'h00 : 8'hFF;
    assign w_triangle   = w_phase_next[7] ? {~w_phase_next[6:0], 1'b0}
                                          : { w_phase_next[6:0], 1'b0};

`ifdef WAVE_GEN_NOISE_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;

    // Feedback taps 8,6,5,4 (bits 7,5,4,3); the LFSR advances on every step
    // regardless of mode so it never stalls in a fixed state.
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_noise     = w_lfsr_next;
`else
    assign w_noise     = 8'h80;
`endif

    always_comb begin
        w_wave = 8'h00;
        case (w_mode_eff)
            2'd0:    w_wave = w_square;
            2'd1:    w_wave = w_phase_next;
            2'd2:    w_wave = w_triangle;
            default: w_wave = w_noise;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div_cnt      <= 16'd0;
            r_phase        <= 8'd0;
            r_active_mode  <= 2'd0;
            r_sample       <= 8'h00;
            r_sample_valid <= 1'b0;
`ifdef WAVE_GEN_NOISE_EN
            r_lfsr         <= 8'h01;
`endif
        end else if (!en) begin
            // Idle: freeze the generator but track the selector directly so
            // the first enabled period starts in the requested mode.
            r_sample_valid <= 1'b0;
            r_active_mode  <= mode;
        end else if (w_step) begin
            r_div_cnt      <= 16'd0;
            r_phase        <= w_phase_next;
            r_active_mode  <= w_mode_eff;
            r_sample       <= w_wave;
            r_sample_valid <= 1'b1;
`ifdef WAVE_GEN_NOISE_EN
            r_lfsr         <= w_lfsr_next;
`endif
        end else begin
            r_div_cnt      <= r_div_cnt + 16'd1;
            r_sample_valid <= 1'b0;
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_wave_gen.sv
module tb_wave_gen;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] freq_div;
    logic [7:0]  sample;
    logic        sample_valid;

    wave_gen dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .mode         (mode),
        .freq_div     (freq_div),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural reference model ----------------
    int m_div, m_phase, m_amode, m_lfsr, m_sample, m_valid;

    function automatic int wave_of(input int ph, input int md, input int noise);
        case (md)
            0:       return (ph < 128) ? 255 : 0;
            1:       return ph;
            2:       return (ph < 128) ? 2 * ph : 2 * (255 - ph);
`ifdef WAVE_GEN_NOISE_EN
            default: return noise;
`else
            default: return 128;
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_div = 0; m_phase = 0; m_amode = 0; m_lfsr = 1; m_sample = 0; m_valid = 0;
    endtask

    task automatic model_clock(input int e, input int md, input int fd);
        int fb;
        if (e == 0) begin
            m_valid = 0;
            m_amode = md;
        end else if (m_div >= fd) begin
            m_div   = 0;
            m_phase = (m_phase + 1) % 256;
            if (m_phase == 0) m_amode = md;
            fb      = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr  = ((m_lfsr * 2) % 256) + fb;
            m_sample = wave_of(m_phase, m_amode, m_lfsr);
            m_valid = 1;
        end else begin
            m_div   = m_div + 1;
            m_valid = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply inputs for one clock, advance the model, settle 1 time unit past the edge.
    task automatic tick(input logic e, input logic [1:0] md, input logic [15:0] fd);
        en = e; mode = md; freq_div = fd;
        @(posedge clk);
        model_clock(int'(e), int'(md), int'(fd));
        #1;
    endtask

    task automatic cmp_model(input string nm);
        check({nm, ".sample"}, {8'h00, sample}, m_sample[15:0]);
        check({nm, ".valid"},  {15'h0, sample_valid}, m_valid[15:0]);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        n_rst = 1'b0;
        #2;
        model_reset();
        check("rst.sample", {8'h00, sample}, 16'h0000);
        check("rst.valid",  {15'h0, sample_valid}, 16'h0000);
        n_rst = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [15:0] fd;
        logic [7:0]  exp_s;
        logic        exp_v;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] tri_s[256];
    logic [7:0] sq_s[256];
    logic [7:0] noise_exp[5];
    int valid_cnt;
    int steps;

    initial begin
        // Directed vectors from reset: sawtooth, freq_div 0, en hold, freq_div lowered.
        vecs[0] = '{1'b0, 2'd1, 16'd0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 16'd0, 8'h01, 1'b1};
        vecs[2] = '{1'b1, 2'd1, 16'd0, 8'h02, 1'b1};
        vecs[3] = '{1'b1, 2'd1, 16'd0, 8'h03, 1'b1};
        vecs[4] = '{1'b0, 2'd1, 16'd0, 8'h03, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 16'd0, 8'h04, 1'b1};
        vecs[6] = '{1'b1, 2'd1, 16'd5, 8'h04, 1'b0};
        vecs[7] = '{1'b1, 2'd1, 16'd0, 8'h05, 1'b1};

`ifdef WAVE_GEN_NOISE_EN
        noise_exp[0] = 8'h02; noise_exp[1] = 8'h04; noise_exp[2] = 8'h08;
        noise_exp[3] = 8'h11; noise_exp[4] = 8'h23;
`else
        for (int i = 0; i < 5; i++) noise_exp[i] = 8'h80;
`endif

        en = 1'b0; mode = 2'd0; freq_div = 16'd0;
        n_rst = 1'b0;
        #2;
        model_reset();
        check("por.sample", {8'h00, sample}, 16'h0000);
        check("por.valid",  {15'h0, sample_valid}, 16'h0000);
        #10;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].en, vecs[i].mode, vecs[i].fd);
            check($sformatf("vec%0d.sample", i), {8'h00, sample}, {8'h00, vecs[i].exp_s});
            check($sformatf("vec%0d.valid", i),  {15'h0, sample_valid}, {15'h0, vecs[i].exp_v});
        end
        // Continue sawtooth to the wrap.
        for (int i = 0; i < 250; i++) begin
            tick(1'b1, 2'd1, 16'd0);
            cmp_model("saw");
        end
        check("saw.at255", {8'h00, sample}, 16'h00FF);
        tick(1'b1, 2'd1, 16'd0);
        check("saw.wrap", {8'h00, sample}, 16'h0000);
        check("saw.wrapv", {15'h0, sample_valid}, 16'h0001);

        // ---- square, freq_div 3 ----
        pulse_reset();
        tick(1'b0, 2'd0, 16'd3);
        valid_cnt = 0; steps = 0;
        for (int i = 0; i < 4 * 130; i++) begin
            tick(1'b1, 2'd0, 16'd3);
            cmp_model("sq");
            check("sq.cadence", {15'h0, sample_valid}, {15'h0, ((i % 4) == 3) ? 1'b1 : 1'b0});
            if (sample_valid) begin
                steps++;
                sq_s[steps % 256] = sample;
            end
        end
        check("sq.steps", steps[15:0], 16'd130);
        check("sq.ph1",   {8'h00, sq_s[1]},   16'h00FF);
        check("sq.ph127", {8'h00, sq_s[127]}, 16'h00FF);
        check("sq.ph128", {8'h00, sq_s[128]}, 16'h0000);

        // ---- triangle, freq_div 0 ----
        pulse_reset();
        tick(1'b0, 2'd2, 16'd0);
        for (int i = 1; i < 256; i++) begin
            tick(1'b1, 2'd2, 16'd0);
            cmp_model("tri");
            tri_s[i] = sample;
        end
        check("tri.ph64",  {8'h00, tri_s[64]},  16'h0080);
        check("tri.ph127", {8'h00, tri_s[127]}, 16'h00FE);
        check("tri.ph128", {8'h00, tri_s[128]}, 16'h00FE);
        check("tri.ph255", {8'h00, tri_s[255]}, 16'h0000);

        // ---- mode change at phase 100 applies only at phase 0 ----
        pulse_reset();
        tick(1'b0, 2'd1, 16'd0);
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 2'd1, 16'd0);
            cmp_model("swA");
        end
        check("sw.ph100", {8'h00, sample}, 16'd100);
        tick(1'b1, 2'd0, 16'd0);
        check("sw.ph101", {8'h00, sample}, 16'd101);
        for (int i = 0; i < 154; i++) begin
            tick(1'b1, 2'd0, 16'd0);
            cmp_model("swB");
        end
        check("sw.ph255", {8'h00, sample}, 16'd255);
        tick(1'b1, 2'd0, 16'd0);
        check("sw.ph0",   {8'h00, sample}, 16'h00FF);
        tick(1'b1, 2'd0, 16'd0);
        check("sw.ph1",   {8'h00, sample}, 16'h00FF);

        // ---- en hold mid-count, then reset mid-count ----
        pulse_reset();
        tick(1'b0, 2'd0, 16'd9);
        for (int i = 0; i < 5; i++) tick(1'b1, 2'd0, 16'd9);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 2'd0, 16'd9);
            check("hold.valid",  {15'h0, sample_valid}, 16'h0000);
            check("hold.sample", {8'h00, sample}, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 2'd0, 16'd9);
            check("resume.wait", {15'h0, sample_valid}, 16'h0000);
        end
        tick(1'b1, 2'd0, 16'd9);
        check("resume.valid",  {15'h0, sample_valid}, 16'h0001);
        check("resume.sample", {8'h00, sample}, 16'h00FF);
        for (int i = 0; i < 3; i++) tick(1'b1, 2'd0, 16'd9);
        pulse_reset();
        tick(1'b0, 2'd1, 16'd9);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 2'd1, 16'd9);
            check("post.wait", {15'h0, sample_valid}, 16'h0000);
        end
        tick(1'b1, 2'd1, 16'd9);
        check("post.valid",  {15'h0, sample_valid}, 16'h0001);
        check("post.sample", {8'h00, sample}, 16'h0001);

        // ---- mode 3 from reset ----
        pulse_reset();
        tick(1'b0, 2'd3, 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 2'd3, 16'd0);
            check($sformatf("noise%0d", i), {8'h00, sample}, {8'h00, noise_exp[i]});
            check("noise.valid", {15'h0, sample_valid}, 16'h0001);
        end

        // ---- randomized run against the model ----
        pulse_reset();
        begin
            logic        r_en;
            logic [1:0]  r_md;
            logic [15:0] r_fd;
            r_md = 2'd0; r_fd = 16'd0;
            for (int i = 0; i < 4000; i++) begin
                r_en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 39) == 0) r_md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) r_fd = 16'($urandom_range(0, 6));
                if ($urandom_range(0, 999) == 0) pulse_reset();
                tick(r_en, r_md, r_fd);
                cmp_model("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
